// File: rtl/sdm_pkg.sv
// Shared types and integrator sizing helpers for the multichannel sigma-delta DAC.
// The integrator width and saturation limit are both derived from the PCM width.
package sdm_pkg;

    typedef enum logic { ST_IDLE, ST_RUN } state_t;

    typedef enum logic { ORD_1ST, ORD_2ND } order_t;

    // Four guard bits let the integrators hold a few full-scale steps of excursion.
    function automatic int integ_width(input int data_w);
        return data_w + 4;
    endfunction

    function automatic longint integ_limit(input int data_w);
        return (longint'(1) <<< (data_w + 2)) - 1;
    endfunction

endpackage

// File: rtl/sdm_mod_core.sv
// One channel of first/second-order sigma-delta modulation with saturating integrators.
// bit_out is the decision for the current tick; the state advances on the tick edge.
module sdm_mod_core
    import sdm_pkg::*;
#(
    parameter int DATA_W = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              clr,
    input  logic              order,
    input  logic [DATA_W-1:0] x,
    output logic              bit_out
);

    localparam int IW = integ_width(DATA_W);
    localparam int SW = IW + 2;
    localparam logic signed [SW-1:0] LIM  = SW'(integ_limit(DATA_W));
    localparam logic signed [SW-1:0] NLIM = -LIM;
    localparam logic signed [SW-1:0] FS   = SW'(longint'(1) <<< (DATA_W - 1));

    logic signed [IW-1:0] i1_q;
    logic signed [IW-1:0] i2_q;
    logic signed [IW-1:0] i1_n;
    logic signed [IW-1:0] i2_n;
    logic signed [SW-1:0] fb;
    logic signed [SW-1:0] sum1;
    logic signed [SW-1:0] sum2;
    logic                 prev_q;
    order_t               ord;

    // Sums are formed two bits wider than the integrators so clamping never sees a wrapped value.
    function automatic logic signed [IW-1:0] clamp(input logic signed [SW-1:0] v);
        if (v > LIM) begin
            return LIM[IW-1:0];
        end
        if (v < NLIM) begin
            return NLIM[IW-1:0];
        end
        return v[IW-1:0];
    endfunction

    assign ord = order_t'(order);

    always_comb begin
        fb      = prev_q ? FS : -FS;
        sum1    = {{(SW-IW){i1_q[IW-1]}}, i1_q} + {{(SW-DATA_W){x[DATA_W-1]}}, x} - fb;
        i1_n    = clamp(sum1);
        sum2    = {{(SW-IW){i2_q[IW-1]}}, i2_q} + {{(SW-IW){i1_n[IW-1]}}, i1_n} - fb;
        i2_n    = clamp(sum2);
        bit_out = (ord == ORD_2ND) ? ~i2_n[IW-1] : ~i1_n[IW-1];
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            i1_q   <= '0;
            i2_q   <= '0;
            prev_q <= 1'b0;
        end else if (tick) begin
            i1_q   <= i1_n;
            i2_q   <= (ord == ORD_2ND) ? i2_n : '0;
            prev_q <= bit_out;
        end
    end

endmodule

// File: rtl/sdm_dac_mc.sv
// Multichannel sigma-delta DAC: frame handshake, tick counter and IDLE/RUN control
// around NUM_CH modulator cores that share one active frame and one modulation order.
module sdm_dac_mc
    import sdm_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int OSR    = 64
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     order_sel,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic [NUM_CH*DATA_W-1:0] din,
    output logic                     valid_out,
    output logic [NUM_CH-1:0]        sdm_out,
    output logic                     frame_start,
    output logic                     underrun
);

    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] LAST = CW'(OSR - 1);

    state_t                   state_q;
    state_t                   state_d;
    order_t                   order_q;
    logic [CW-1:0]            cnt_q;
    logic [NUM_CH*DATA_W-1:0] pending_q;
    logic [NUM_CH*DATA_W-1:0] active_q;
    logic                     pending_full_q;
    logic                     rdy_q;
    logic                     underrun_q;
    logic                     accept;
    logic                     at_end;
    logic                     load;
    logic                     clr_int;
    logic                     set_underrun;
    logic                     running;
    logic [NUM_CH-1:0]        mod_bits;

    // rdy_q holds ready_in low during the reset cycle itself even though pending is empty.
    assign ready_in = rdy_q & ~pending_full_q;
    assign accept   = valid_in & ready_in;
    assign running  = (state_q == ST_RUN);
    assign at_end   = running && (cnt_q == LAST);

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        clr_int      = 1'b0;
        set_underrun = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr_int = 1'b1;
                if (enable && pending_full_q) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (at_end) begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                        clr_int = 1'b1;
                    end else if (pending_full_q) begin
                        load    = 1'b1;
                        clr_int = (order_t'(order_sel) != order_q);
                    end else begin
                        set_underrun = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            order_q        <= ORD_1ST;
            cnt_q          <= '0;
            pending_q      <= '0;
            active_q       <= '0;
            pending_full_q <= 1'b0;
            rdy_q          <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rdy_q          <= 1'b1;
            underrun_q     <= underrun_q | set_underrun;
            pending_full_q <= accept | (pending_full_q & ~load);
            if (accept) begin
                pending_q <= din;
            end
            if (load) begin
                active_q <= pending_q;
                order_q  <= order_t'(order_sel);
            end
            if (running && !at_end) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        sdm_mod_core #(.DATA_W(DATA_W)) u_core (
            .clk     (clk),
            .rst     (rst),
            .tick    (running),
            .clr     (clr_int),
            .order   (logic'(order_q)),
            .x       (active_q[k*DATA_W +: DATA_W]),
            .bit_out (mod_bits[k])
        );
    end

    assign valid_out   = running;
    assign frame_start = running && (cnt_q == '0);
    assign sdm_out     = running ? mod_bits : '0;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_sdm_dac_mc.sv
// Directed bench for sdm_dac_mc: table of per-frame density vectors plus hand-built
// sequences for latency, backpressure, underrun, order change and mid-frame reset.
module tb_sdm_dac_mc;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 16;
    localparam int OSR    = 64;
    localparam int IMAX   = (1 << (DATA_W + 2)) - 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     enable = 1'b0;
    logic                     order_sel = 1'b0;
    logic                     valid_in = 1'b0;
    logic                     ready_in;
    logic [NUM_CH*DATA_W-1:0] din = '0;
    logic                     valid_out;
    logic [NUM_CH-1:0]        sdm_out;
    logic                     frame_start;
    logic                     underrun;

    int checks = 0;
    int errors = 0;
    int satViol = 0;
    int peakI2 = 0;
    int i1v, i2v;

    typedef struct {
        logic        ord;
        logic [15:0] x0;
        logic [15:0] x1;
        int          lo0;
        int          hi0;
        int          lo1;
        int          hi1;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    sdm_dac_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OSR(OSR)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .order_sel   (order_sel),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .din         (din),
        .valid_out   (valid_out),
        .sdm_out     (sdm_out),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    // Integrator bound watch on channel 0 for the whole run.
    always @(negedge clk) begin
        i1v = int'(dut.g_ch[0].u_core.i1_q);
        i2v = int'(dut.g_ch[0].u_core.i2_q);
        if (i1v > IMAX || i1v < -IMAX || i2v > IMAX || i2v < -IMAX) satViol++;
        if (i2v > peakI2) peakI2 = i2v;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        valid_in = 1'b0;
        enable = 1'b0;
        order_sel = 1'b0;
        din = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic ord, input logic [15:0] x0, input logic [15:0] x1);
        order_sel = ord;
        din = {x1, x0};
        enable = 1'b1;
        valid_in = 1'b1;
    endtask

    task automatic pushFrame(input logic [15:0] x);
        din = {x, x};
        valid_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (ready_in) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
    endtask

    task automatic waitFrameStart(input string name);
        for (int i = 0; i < 300 && !frame_start; i++) @(negedge clk);
        checkOutput(name, int'(frame_start), 1);
    endtask

    task automatic countFrame(output int ones0, output int ones1, output int starts,
                              output logic [63:0] bits0);
        ones0 = 0;
        ones1 = 0;
        starts = 0;
        bits0 = '0;
        for (int i = 0; i < OSR; i++) begin
            ones0 += int'(sdm_out[0]);
            ones1 += int'(sdm_out[1]);
            starts += int'(frame_start);
            bits0[i] = sdm_out[0];
            @(negedge clk);
        end
    endtask

    initial begin
        int o0, o1, st, accepts, alt, vcnt;
        logic [63:0] b0;
        logic [5:0] first6;

        vecs[0] = '{1'b0, 16'h0000, 16'h7FFF, 32, 33, 62, 64};
        vecs[1] = '{1'b1, 16'h7FFF, 16'h8000, 62, 64, 0, 2};
        vecs[2] = '{1'b0, 16'h8000, 16'h4000, 0, 1, 48, 50};
        vecs[3] = '{1'b1, 16'h0000, 16'h0000, 32, 34, 32, 34};

        // Reset state and release.
        repeat (2) @(negedge clk);
        checkOutput("rst valid_out", int'(valid_out), 0);
        checkOutput("rst ready_in", int'(ready_in), 0);
        checkOutput("rst underrun", int'(underrun), 0);
        checkOutput("rst sdm_out", int'(sdm_out), 0);
        checkOutput("rst frame_start", int'(frame_start), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready after rst", int'(ready_in), 1);

        // Latency: accept at t, first valid bit at t+2; first-order x=0 begins 1,1,0,1,0,1.
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("lat t+1 valid_out", int'(valid_out), 0);
        checkOutput("lat t+1 ready_in", int'(ready_in), 0);
        @(negedge clk);
        checkOutput("lat t+2 valid_out", int'(valid_out), 1);
        checkOutput("lat t+2 frame_start", int'(frame_start), 1);
        for (int i = 0; i < 6; i++) begin
            first6[i] = sdm_out[0];
            @(negedge clk);
        end
        checkOutput("lat first bits 1st order", int'(first6), 6'b101011);

        // Density vectors, each from a clean reset with the frame continuously offered.
        for (int v = 0; v < 4; v++) begin
            doReset();
            applyStimulus(vecs[v].ord, vecs[v].x0, vecs[v].x1);
            waitFrameStart($sformatf("vec%0d start", v));
            countFrame(o0, o1, st, b0);
            checkRange($sformatf("vec%0d ones ch0", v), o0, vecs[v].lo0, vecs[v].hi0);
            checkRange($sformatf("vec%0d ones ch1", v), o1, vecs[v].lo1, vecs[v].hi1);
            checkOutput($sformatf("vec%0d frame_start pulses", v), st, 1);
            checkOutput($sformatf("vec%0d underrun", v), int'(underrun), 0);
        end
        checkOutput("sat violations", satViol, 0);
        checkOutput("i2 peak reaches limit", peakI2, IMAX);

        // Backpressure: one accept per frame, ready low while pending is full.
        doReset();
        applyStimulus(1'b0, 16'h1234, 16'h1234);
        waitFrameStart("bp start");
        accepts = 0;
        for (int i = 0; i < 3 * OSR; i++) begin
            if (valid_in && ready_in) accepts++;
            if (i % OSR == 32) checkOutput($sformatf("bp ready mid %0d", i / OSR), int'(ready_in), 0);
            @(negedge clk);
        end
        checkOutput("bp accepts", accepts, 3);

        // Disable at count 0: the current frame completes, then IDLE with cleared integrators.
        checkOutput("bp frame_start before disable", int'(frame_start), 1);
        enable = 1'b0;
        valid_in = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 100 && valid_out; i++) begin
            vcnt++;
            @(negedge clk);
        end
        checkOutput("disable run length", vcnt, OSR);
        checkOutput("idle i1 cleared", int'(dut.g_ch[0].u_core.i1_q), 0);
        checkOutput("disable underrun", int'(underrun), 0);

        // Underrun: two frames then nothing; the third frame repeats frame two.
        doReset();
        enable = 1'b1;
        order_sel = 1'b0;
        pushFrame(16'h0000);
        pushFrame(16'h7FFF);
        checkOutput("ur early", int'(underrun), 0);
        waitFrameStart("ur frame2 start");
        checkOutput("ur at frame2", int'(underrun), 0);
        countFrame(o0, o1, st, b0);
        checkRange("ur frame2 ones", o0, 62, 64);
        checkOutput("ur frame3 start", int'(frame_start), 1);
        checkOutput("ur flag at frame3", int'(underrun), 1);
        countFrame(o0, o1, st, b0);
        checkRange("ur frame3 ones", o0, 62, 64);
        checkOutput("ur sticky", int'(underrun), 1);

        // Order change mid-frame only takes effect at the next boundary, from zeroed state.
        doReset();
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        waitFrameStart("ord start");
        for (int i = 0; i < OSR; i++) begin
            b0[i] = sdm_out[0];
            if (i == 10) order_sel = 1'b1;
            @(negedge clk);
        end
        alt = 0;
        for (int i = 20; i < OSR; i++) if (b0[i] == b0[i-1]) alt++;
        checkOutput("ord still 1st order alternation", alt, 0);
        checkOutput("ord boundary frame_start", int'(frame_start), 1);
        checkOutput("ord boundary i1", int'(dut.g_ch[0].u_core.i1_q), 0);
        checkOutput("ord boundary i2", int'(dut.g_ch[0].u_core.i2_q), 0);
        for (int i = 0; i < 6; i++) begin
            first6[i] = sdm_out[0];
            @(negedge clk);
        end
        checkOutput("ord first bits 2nd order", int'(first6), 6'b001011);

        // Mid-frame reset.
        doReset();
        applyStimulus(1'b0, 16'h0000, 16'h0000);
        waitFrameStart("mr start");
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mr valid_out in rst", int'(valid_out), 0);
        checkOutput("mr ready_in in rst", int'(ready_in), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mr ready after release", int'(ready_in), 1);
        @(negedge clk);
        checkOutput("mr valid_out before frame", int'(valid_out), 0);
        @(negedge clk);
        checkOutput("mr fresh valid_out", int'(valid_out), 1);
        checkOutput("mr fresh frame_start", int'(frame_start), 1);
        checkOutput("mr underrun", int'(underrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdm_dac_mc.md
SDM_DAC_MC -- requirements
Module: sdm_dac_mc

Interface
REQ-001 The block SHALL have the parameter NUM_CH, default 2, giving the number of independent channels (legal range 1..8).
REQ-002 The block SHALL have the parameter DATA_W, default 16, giving the signed PCM sample width (legal range 8..24).
REQ-003 The block SHALL have the parameter OSR, default 64, giving the modulator ticks per PCM frame (legal range 4..1024).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  1 = run the modulators; 0 = finish the current frame, then go idle.
REQ-008 order_sel  in  1  0 = first-order modulation, 1 = second-order modulation; sampled only at frame boundaries.
REQ-009 valid_in  in  1  a PCM frame is presented on din.
REQ-010 ready_in  out  1  the block can accept a frame this cycle.
REQ-011 din  in  NUM_CH*DATA_W  packed signed frame; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 valid_out  out  1  sdm_out carries a new bit this cycle.
REQ-013 sdm_out  out  NUM_CH  one modulator bit per channel.
REQ-014 frame_start  out  1  one-cycle pulse on the first tick of each frame.
REQ-015 underrun  out  1  sticky flag: a frame boundary arrived with no pending frame.

Function
REQ-016 The block SHALL accept a frame on a cycle where valid_in and ready_in are both 1.
REQ-017 The block SHALL hold an accepted frame in a pending register; ready_in SHALL equal NOT pending_full.
REQ-018 The block SHALL have the states IDLE and RUN.
REQ-019 IDLE -> RUN SHALL occur when enable=1 and pending_full=1; pending then moves to the active register and the order is latched from order_sel.
REQ-020 In RUN, a tick counter SHALL count 0..OSR-1, advancing every cycle.
REQ-021 In RUN, valid_out SHALL be 1 every cycle, and frame_start SHALL be 1 when the count is 0.
REQ-022 At count OSR-1 with enable=1 and pending_full=1, the block SHALL load pending into active, clear pending_full and latch the order from order_sel.
REQ-023 At count OSR-1 with enable=1 and pending empty, the block SHALL repeat the active frame and set underrun.
REQ-024 At count OSR-1 with enable=0, the block SHALL go to IDLE and clear the integrators.
REQ-025 An accept and a pending->active transfer in the same cycle SHALL leave pending_full=1 holding the new frame.
REQ-026 Latency: a frame accepted at cycle t while in IDLE with enable=1 SHALL produce its first valid sdm_out at cycle t+2.
REQ-027 First-order mode, per channel: fb = +2^(DATA_W-1) if the previous bit is 1, else -2^(DATA_W-1); i1 += x - fb; bit = (i1 >= 0).
REQ-028 Second-order mode, per channel: i1 += x - fb; i2 += i1 - fb; bit = (i2 >= 0).
REQ-029 Integrators SHALL be DATA_W+4 bits signed and saturate at ±(2^(DATA_W+2)-1); they SHALL never wrap.
REQ-030 An order change at a frame boundary SHALL zero i1 and i2 and the previous bit (the previous bit reads as 0, i.e. fb = -FS) before the first tick of the new frame.
REQ-031 In IDLE, sdm_out, valid_out and frame_start SHALL be 0.
REQ-032 underrun SHALL clear only on reset.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL enter IDLE with all outputs 0, ready_in=0, underrun=0, pending empty, integrators and counter 0.
REQ-034 ready_in SHALL become 1 on the first cycle after rst deasserts.
REQ-035 A reset mid-frame SHALL discard the active and pending frames without emitting any further valid_out.

Structure
REQ-036 The package sdm_pkg SHALL hold the state enum, the order enum (ORD_1ST, ORD_2ND) and the integrator width/saturation functions of DATA_W.
REQ-037 The per-channel modulator SHALL be the sub-module sdm_mod_core, instantiated NUM_CH times by generate; it takes x, tick, clr and order, and returns the bit.
REQ-038 Framing, handshake, the counter and the FSM SHALL live in sdm_dac_mc only.

Verification
REQ-039 Verify first order, x=0, OSR=64: ones count = 32±1 per frame and the bit alternates after settling.
REQ-040 Verify x=0x7FFF (second order) -> ones ≥62 of 64; x=0x8000 -> ones ≤2 of 64; the integrators never exceed the saturation bound.
REQ-041 Verify backpressure: hold valid_in=1 -> ready_in=0 while pending is full, and exactly one frame is accepted per 64 cycles with no loss.
REQ-042 Verify underrun: stop valid_in after 2 frames -> underrun=1 at the third boundary, and the output keeps the frame-2 density.
REQ-043 Verify order_sel toggled mid-frame -> no effect until the next frame_start; the integrators read 0 at that boundary.
REQ-044 Verify rst asserted mid-frame -> valid_out=0 on the next cycle, ready_in=1 one cycle after release, and a fresh frame appears after 2 cycles.
